mem_port_ctrl: RTL and testbench
================================

Name: mem_port_ctrl

Overview:
- Bus-master side of the CPU's single-port synchronous RAM.
- Accepts instruction-fetch and data load/store requests from the datapath over a req/gnt handshake, arbitrating between them.
- Drives the RAM address, write-data, write-enable and read-enable pins, absorbs the RAM's one-edge registered read latency, and returns read data with a one-cycle valid pulse.
- Sits between the control unit / MAR-MDR logic and the RAM.

Parameters:
- DATA_W, 32, data width of the RAM and both request ports.
- ADDR_W, 8, RAM address width; both request ports use the same width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetched instruction word
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle pulse; d_rdata valid (loads only)
- d_rdata  out  DATA_W  load data
- d_wack  out  1  one-cycle pulse; store committed to RAM
- busy  out  1  high in any state other than IDLE
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_we  out  1  RAM write enable
- ram_re  out  1  RAM read enable
- ram_rdata  in  DATA_W  RAM registered read data; valid after the edge at which ram_re was sampled high

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE.
  - All outputs 0: ram_addr, ram_wdata, ram_we, ram_re, both rdata buses, all gnt/rvalid/wack pulses, busy.
  - An in-flight transaction is dropped; no rvalid or wack is issued for it after reset release.
- Grants:
  - Combinational, asserted only in IDLE.
  - d_gnt = d_req.
  - if_gnt = if_req & ~d_req; data has fixed priority over fetch.
  - Never both high in the same cycle.
- Requester rules:
  - Requester holds req/addr/wdata/we stable until it sees gnt.
  - Values are sampled on the edge where gnt=1.
  - A requester may drop req after gnt or re-request immediately.
- FSM states: IDLE, ISSUE_RD, CAPTURE, ISSUE_WR.
  - IDLE, grant edge, load or fetch → ISSUE_RD. Register ram_addr, ram_re=1, ram_we=0, and a source tag (fetch/data).
  - IDLE, grant edge, store → ISSUE_WR. Register ram_addr, ram_wdata, ram_we=1, ram_re=0.
  - ISSUE_RD → CAPTURE. The RAM samples the address on this edge. Controller drives ram_re=0.
  - CAPTURE → IDLE. Latch ram_rdata into the tagged port's rdata and pulse that port's rvalid for exactly one cycle. The other port's rdata holds its old value.
  - ISSUE_WR → IDLE. The RAM writes on this edge. Controller drives ram_we=0 and pulses d_wack for one cycle.
- Latency:
  - Read: grant edge E0, rvalid high in the cycle after E2 (2 cycles).
  - Write: wack high in the cycle after E1.
  - A new grant is possible in the same cycle rvalid or wack is high (state is IDLE).
  - Peak throughput: 1 read per 3 cycles, 1 write per 2 cycles.
- Invariants:
  - ram_we and ram_re are never both 1.
  - Each is high for exactly one cycle per transaction.
  - ram_addr and ram_wdata hold their last values between transactions.
- Edge cases:
  - Fetch starves while d_req is continuously asserted; this is an accepted policy.
  - The datapath guarantees no fetch/data overlap in a well-formed CPU.
- Width: addresses pass through unmodified; no wrap or offset arithmetic inside the block. Address 0xFF is legal.

Decomposition:
- Package mem_port_pkg:
  - state enum {IDLE, ISSUE_RD, CAPTURE, ISSUE_WR}
  - source-tag constants SRC_IF, SRC_D
  - default DATA_W/ADDR_W localparams
- One natural sub-module: mem_port_arb, the combinational fixed-priority grant logic (inputs: idle, if_req, d_req; outputs: if_gnt, d_gnt, src).
- FSM and datapath registers stay in the top module.

Test Plan:
- Reset mid-read: assert rst_n=0 in CAPTURE → all outputs 0 immediately; after release, no d_rvalid/if_rvalid pulse appears.
- Store then load:
  - d_req, d_we=1, addr 0x52, wdata 0x0000002F → ram_we high for one cycle with ram_addr=0x52; d_wack one cycle later.
  - Load 0x52 → d_rvalid with d_rdata=0x2F exactly 2 cycles after d_gnt.
- Fetch: preload RAM[0]=0x02000054, if_req addr 0 → if_rvalid with if_rdata=0x02000054 2 cycles after if_gnt; d_rdata unchanged.
- Simultaneous requests: if_req and d_req (load 0x68, RAM=0xBC) in the same cycle → d_gnt first, d_rdata=0xBC; if_gnt on the cycle d_rvalid is high.
- Back-to-back: 4 consecutive loads at 0x00..0x03 → grants spaced exactly 3 cycles apart; data in order; ram_we/ram_re never both high (assertion).
- Boundary address 0xFF: store 0xDEADBEEF, load back → 0xDEADBEEF; busy high only during non-IDLE cycles.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Shared types and constants for the RAM bus-master port controller.
package mem_port_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE_RD,
        CAPTURE,
        ISSUE_WR
    } state_e;

    localparam logic SRC_IF = 1'b0;
    localparam logic SRC_D  = 1'b1;

endpackage

// File: rtl/mem_port_arb.sv
// Fixed-priority grant logic; data requests always win over fetch.
module mem_port_arb
    import mem_port_pkg::*;
(
    input  logic idle,
    input  logic if_req,
    input  logic d_req,
    output logic if_gnt,
    output logic d_gnt,
    output logic src
);

    always_comb begin
        d_gnt  = idle & d_req;
        if_gnt = idle & if_req & ~d_req;
        src    = d_req ? SRC_D : SRC_IF;
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// Bus-master controller for the single-port synchronous RAM:
// arbitrates fetch/data requests and absorbs the one-edge read latency.
module mem_port_ctrl
    import mem_port_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_wack,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_e            state_q, state_d;
    logic              src_q, src_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic              d_wack_q, d_wack_d;
    logic              idle;
    logic              arb_src;

    // No grant can be issued while reset is held.
    assign idle = rst_n & (state_q == IDLE);

    mem_port_arb u_arb (
        .idle   (idle),
        .if_req (if_req),
        .d_req  (d_req),
        .if_gnt (if_gnt),
        .d_gnt  (d_gnt),
        .src    (arb_src)
    );

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        d_wack_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (d_gnt && d_we) begin
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    src_d   = arb_src;
                    we_d    = 1'b1;
                    state_d = ISSUE_WR;
                end else if (d_gnt || if_gnt) begin
                    addr_d  = d_gnt ? d_addr : if_addr;
                    src_d   = arb_src;
                    re_d    = 1'b1;
                    state_d = ISSUE_RD;
                end
            end
            ISSUE_RD: state_d = CAPTURE;
            CAPTURE: begin
                state_d = IDLE;
                if (src_q == SRC_D) begin
                    d_rdata_d  = ram_rdata;
                    d_rvalid_d = 1'b1;
                end else begin
                    if_rdata_d  = ram_rdata;
                    if_rvalid_d = 1'b1;
                end
            end
            ISSUE_WR: begin
                state_d  = IDLE;
                d_wack_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            src_q       <= SRC_IF;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_wack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            re_q        <= re_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            d_wack_q    <= d_wack_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_we    = we_q;
    assign ram_re    = re_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_wack    = d_wack_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a registered-read RAM model.
module tb_mem_port_ctrl;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_wack;
    logic        busy;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata;

    logic [31:0] mem [0:255];
    int          checks;
    int          errors;
    int          cyc;
    int          gnt_cyc;
    int          prev_gnt;
    logic        run;

    mem_port_ctrl #(.DATA_W(32), .ADDR_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_wack    (d_wack),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_re    (ram_re),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (run && rst_n) chk("we_re_excl", {63'd0, ram_we & ram_re}, 64'd0);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [7:0] a, input logic [31:0] wd);
        d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = wd;
        #1;
        chk("st_gnt", {63'd0, d_gnt}, 64'd1);
        step;
        d_req = 1'b0; d_we = 1'b0;
        chk("st_we", {63'd0, ram_we}, 64'd1);
        chk("st_re", {63'd0, ram_re}, 64'd0);
        chk("st_addr", {56'd0, ram_addr}, {56'd0, a});
        chk("st_wdata", {32'd0, ram_wdata}, {32'd0, wd});
        chk("st_busy", {63'd0, busy}, 64'd1);
        step;
        chk("st_wack", {63'd0, d_wack}, 64'd1);
        chk("st_we_off", {63'd0, ram_we}, 64'd0);
        chk("st_idle", {63'd0, busy}, 64'd0);
    endtask

    task automatic do_read(input logic is_d, input logic [7:0] a,
                           input logic [31:0] exp);
        if (is_d) begin
            d_req = 1'b1; d_we = 1'b0; d_addr = a;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        #1;
        chk("rd_gnt", {63'd0, is_d ? d_gnt : if_gnt}, 64'd1);
        gnt_cyc = cyc;
        step;
        d_req = 1'b0; if_req = 1'b0;
        chk("rd_re", {63'd0, ram_re}, 64'd1);
        chk("rd_addr", {56'd0, ram_addr}, {56'd0, a});
        chk("rd_busy", {63'd0, busy}, 64'd1);
        step;
        chk("rd_re_off", {63'd0, ram_re}, 64'd0);
        chk("rd_early", {63'd0, d_rvalid | if_rvalid}, 64'd0);
        step;
        chk("rd_rvalid", {62'd0, d_rvalid, if_rvalid},
            is_d ? 64'd2 : 64'd1);
        chk("rd_data", {32'd0, is_d ? d_rdata : if_rdata}, {32'd0, exp});
        chk("rd_idle", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; run = 1'b0;
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        ram_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h00] = 32'h0200_0054;
        mem[8'h01] = 32'h0000_0011;
        mem[8'h02] = 32'h0000_0022;
        mem[8'h03] = 32'h0000_0033;
        mem[8'h10] = 32'hA5A5_0010;
        mem[8'h68] = 32'h0000_00BC;

        #22;
        chk("rst_outs", {busy, ram_we, ram_re, d_gnt, if_gnt,
                         d_rvalid, if_rvalid, d_wack, ram_addr}, 64'd0);
        chk("rst_data", {if_rdata, d_rdata | ram_wdata}, 64'd0);
        rst_n = 1'b1;
        run = 1'b1;
        step;

        do_store(8'h52, 32'h0000_002F);
        do_read(1'b1, 8'h52, 32'h0000_002F);
        step;
        chk("wack_pulse", {63'd0, d_wack}, 64'd0);

        do_read(1'b0, 8'h00, 32'h0200_0054);
        chk("fetch_d_hold", {32'd0, d_rdata}, 64'h2F);
        step;
        chk("rvalid_pulse", {63'd0, if_rvalid}, 64'd0);

        if_req = 1'b1; if_addr = 8'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h68;
        #1;
        chk("sim_gnt", {62'd0, d_gnt, if_gnt}, 64'd2);
        step;
        d_req = 1'b0;
        chk("sim_if_wait", {63'd0, if_gnt}, 64'd0);
        step;
        step;
        chk("sim_d_rvalid", {63'd0, d_rvalid}, 64'd1);
        chk("sim_d_data", {32'd0, d_rdata}, 64'hBC);
        chk("sim_if_gnt", {63'd0, if_gnt}, 64'd1);
        step;
        if_req = 1'b0;
        step;
        step;
        chk("sim_if_rvalid", {63'd0, if_rvalid}, 64'd1);
        chk("sim_if_data", {32'd0, if_rdata}, 64'hA5A5_0010);
        chk("sim_d_hold", {32'd0, d_rdata}, 64'hBC);
        step;

        prev_gnt = 0;
        for (int i = 0; i < 4; i++) begin
            do_read(1'b1, 8'(i), mem[i]);
            if (i > 0) chk("b2b_space", 64'(gnt_cyc - prev_gnt), 64'd3);
            prev_gnt = gnt_cyc;
        end
        step;

        do_store(8'hFF, 32'hDEAD_BEEF);
        do_read(1'b1, 8'hFF, 32'hDEAD_BEEF);
        step;

        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h01;
        step;
        d_req = 1'b0;
        step;
        chk("mid_capture", {63'd0, busy}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {busy, ram_we, ram_re, d_gnt, if_gnt,
                             d_rvalid, if_rvalid, d_wack, ram_addr}, 64'd0);
        chk("mid_rst_data", {if_rdata, d_rdata | ram_wdata}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step;
            chk("post_rst_quiet", {61'd0, d_rvalid, if_rvalid, busy}, 64'd0);
        end

        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
